// File: rtl/gpio_sampler.sv
// gpio_sampler_fifo: generic synchronous FIFO for sampled pin words.
// Latency: a pushed word is at the head the cycle after the push.
// Backpressure: a push is refused only when full with no same-cycle pop; push_acc_o reports acceptance.
module gpio_sampler_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  output logic                   push_acc_o,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop_acc;

  assign empty_o    = (level_q == '0);
  assign pop_acc    = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc_o = push_i & ((level_q != FULL_LVL) | pop_acc);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Pointer and fill-level next state; simultaneous push and pop keep the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc_o) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_acc_o & ~pop_acc)      level_d = level_q + LVL_ONE;
    else if (pop_acc & ~push_acc_o) level_d = level_q - LVL_ONE;
  end

  // Pointer/level registers; reset empties the FIFO and discards its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only meaningful below the fill level.
  always_ff @(posedge clk_i) begin
    if (push_acc_o) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// gpio_sampler: GPIO with direction/output registers and a divider-timed input sampler feeding a FIFO.
// Latency: pins reach the sampler after 2 sync flops; a sample is on rx the cycle after its tick; read response 1 cycle.
// Backpressure: rx_wren_o never while rx_full_i; a pending response stalls tx_rden_o; samples are dropped when the FIFO is full.
module gpio_sampler #(
  parameter int          NUM_PINS   = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] PERIPH_ID  = 24'h000001
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PINS-1:0] in_i,
  output logic [NUM_PINS-1:0] out_o,
  output logic [NUM_PINS-1:0] tristate_o,
  input  logic [28:0]         tx_data_i,
  input  logic                tx_empty_i,
  output logic                tx_rden_o,
  output logic [28:0]         rx_data_o,
  output logic                rx_wren_o,
  input  logic                rx_full_i,
  output logic                idle_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic        cfg;
    logic        wr;
    logic [2:0]  addr;
    logic [23:0] dat;
  } pkt_t;

  typedef struct packed {
    logic        cfg;
    logic        ovf;
    logic [2:0]  seq;
    logic [23:0] dat;
  } smp_t;

  pkt_t                tx_pkt;
  logic                cfg_wr, cfg_rd, data_wr, div_wr, status_wr;
  logic [23:0]         rd_val;
  logic                tick, changed, push_req, push_acc, drop, pop;
  smp_t                smp;
  logic [28:0]         fifo_head;
  logic                fifo_empty;
  logic [LW-1:0]       fifo_level;

  logic [NUM_PINS-1:0] sync1_q, sync_q;
  logic                en_q, en_d, mode_q, mode_d;
  logic [23:0]         div_q, div_d, cnt_q, cnt_d;
  logic [NUM_PINS-1:0] dir_q, dir_d, out_q, out_d, emask_q, emask_d, last_q, last_d;
  logic [2:0]          seq_q, seq_d;
  logic                pend_ovf_q, pend_ovf_d, ovf_sticky_q, ovf_sticky_d;
  pkt_t                resp_q, resp_d;
  logic                resp_pend_q, resp_pend_d;
  logic                idle_q, idle_d;

  assign tx_pkt    = pkt_t'(tx_data_i);
  assign tx_rden_o = ~tx_empty_i & ~resp_pend_q;
  assign cfg_wr    = tx_rden_o & tx_pkt.cfg & tx_pkt.wr;
  assign cfg_rd    = tx_rden_o & tx_pkt.cfg & ~tx_pkt.wr;
  assign data_wr   = tx_rden_o & ~tx_pkt.cfg;
  assign div_wr    = cfg_wr & (tx_pkt.addr == 3'd1);
  assign status_wr = cfg_wr & (tx_pkt.addr == 3'd5);

  assign out_o      = out_q;
  assign tristate_o = ~dir_q;

  // Responses win the rx port over samples; samples leave only when no response waits.
  assign rx_wren_o = ~rx_full_i & (resp_pend_q | ~fifo_empty);
  assign rx_data_o = resp_pend_q ? resp_q : fifo_head;
  assign pop       = rx_wren_o & ~resp_pend_q;
  assign idle_o    = idle_q;

  assign tick     = en_q & (cnt_q == div_q);
  assign changed  = |((sync_q ^ last_q) & emask_q);
  assign push_req = tick & (~mode_q | changed);
  assign drop     = push_req & ~push_acc;
  assign smp      = '{cfg: 1'b0, ovf: pend_ovf_q, seq: seq_q, dat: 24'(sync_q)};

  gpio_sampler_fifo #(
    .WIDTH(29),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_req),
    .push_dat_i (smp),
    .push_acc_o (push_acc),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  // Register read mux; pin-width registers are zero-extended so unused bits read 0.
  always_comb begin
    rd_val = '0;
    case (tx_pkt.addr)
      3'd0:    rd_val = {22'd0, mode_q, en_q};
      3'd1:    rd_val = div_q;
      3'd2:    rd_val = 24'(dir_q);
      3'd3:    rd_val = 24'(out_q);
      3'd4:    rd_val = 24'(emask_q);
      3'd5:    rd_val = {8'd0, 8'(fifo_level), 7'd0, ovf_sticky_q};
      3'd7:    rd_val = PERIPH_ID;
      default: rd_val = '0;
    endcase
  end

  // Host-visible register updates from config writes and data packets.
  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    div_d   = div_q;
    dir_d   = dir_q;
    out_d   = out_q;
    emask_d = emask_q;
    if (cfg_wr) begin
      case (tx_pkt.addr)
        3'd0:    begin en_d = tx_pkt.dat[0]; mode_d = tx_pkt.dat[1]; end
        3'd1:    div_d   = tx_pkt.dat;
        3'd2:    dir_d   = tx_pkt.dat[NUM_PINS-1:0];
        3'd3:    out_d   = tx_pkt.dat[NUM_PINS-1:0];
        3'd4:    emask_d = tx_pkt.dat[NUM_PINS-1:0];
        default: ;
      endcase
    end
    if (data_wr) out_d = tx_pkt.dat[NUM_PINS-1:0];
  end

  // Divider, change reference, sequence/overflow tracking and read-response holding.
  always_comb begin
    // Counter idles at 0 while disabled so enabling always starts a full period.
    if (~en_q | ~en_d | div_wr | tick) cnt_d = '0;
    else                               cnt_d = cnt_q + 24'd1;

    last_d = last_q;
    if ((~en_q & en_d) | tick) last_d = sync_q;

    seq_d      = push_acc ? seq_q + 3'd1 : seq_q;
    pend_ovf_d = pend_ovf_q;
    if (drop)          pend_ovf_d = 1'b1;
    else if (push_acc) pend_ovf_d = 1'b0;

    ovf_sticky_d = ovf_sticky_q;
    if (status_wr) ovf_sticky_d = 1'b0;
    if (drop)      ovf_sticky_d = 1'b1;

    resp_d      = resp_q;
    resp_pend_d = resp_pend_q;
    if (cfg_rd) begin
      resp_d      = '{cfg: 1'b1, wr: 1'b0, addr: tx_pkt.addr, dat: rd_val};
      resp_pend_d = 1'b1;
    end else if (rx_wren_o & resp_pend_q) begin
      resp_pend_d = 1'b0;
    end

    idle_d = fifo_empty & ~resp_pend_q;
  end

  // State registers; reset restores register defaults and drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      en_q         <= 1'b0;
      mode_q       <= 1'b0;
      div_q        <= 24'd6250000;
      dir_q        <= '0;
      out_q        <= '0;
      emask_q      <= '1;
      cnt_q        <= '0;
      last_q       <= '0;
      seq_q        <= '0;
      pend_ovf_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
      resp_q       <= '0;
      resp_pend_q  <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      sync1_q      <= in_i;
      sync_q       <= sync1_q;
      en_q         <= en_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      dir_q        <= dir_d;
      out_q        <= out_d;
      emask_q      <= emask_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      seq_q        <= seq_d;
      pend_ovf_q   <= pend_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
      resp_q       <= resp_d;
      resp_pend_q  <= resp_pend_d;
      idle_q       <= idle_d;
    end
  end
endmodule

// File: tb/tb_gpio_sampler.sv
// tb_gpio_sampler: directed vector table for the register path plus hand-written sampler sequences.
// Inputs are driven 1 time unit after the rising edge; rx words are captured on the falling edge.
// Expected words are built from the packet formats by small helper functions.
module tb_gpio_sampler;
  logic        clk, rst_n;
  logic [15:0] pins_in, pins_out, pins_tri;
  logic [28:0] tx_data, rx_data;
  logic        tx_empty, tx_rden, rx_wren, rx_full, idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wren_full_hits = 0;
  int exp_seq = 0;
  logic [28:0] rxq[$];
  int          rxts[$];

  typedef struct {
    logic [28:0] pkt;
    logic        has_resp;
    logic [28:0] resp;
    logic [15:0] out_e;
    logic [15:0] tri_e;
  } vec_t;
  vec_t vecs[$];

  gpio_sampler #(
    .NUM_PINS   (16),
    .FIFO_DEPTH (8),
    .PERIPH_ID  (24'h000001)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_i       (pins_in),
    .out_o      (pins_out),
    .tristate_o (pins_tri),
    .tx_data_i  (tx_data),
    .tx_empty_i (tx_empty),
    .tx_rden_o  (tx_rden),
    .rx_data_o  (rx_data),
    .rx_wren_o  (rx_wren),
    .rx_full_i  (rx_full),
    .idle_o     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // rx capture: a word transfers at the edge following a falling-edge sample with rx_wren high.
  always @(negedge clk) begin
    if (rst_n && rx_wren) begin
      rxq.push_back(rx_data);
      rxts.push_back(cyc);
    end
    if (rx_wren && rx_full) wren_full_hits <= wren_full_hits + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] rd_pkt(input logic [2:0] a);
    return {1'b1, 1'b0, a, 24'h000000};
  endfunction
  function automatic logic [28:0] wr_pkt(input logic [2:0] a, input logic [23:0] d);
    return {1'b1, 1'b1, a, d};
  endfunction
  function automatic logic [28:0] rsp(input logic [2:0] a, input logic [23:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction
  function automatic logic [28:0] smp(input logic o, input logic [2:0] s, input logic [23:0] d);
    return {1'b0, o, s, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [28:0] exp);
    logic [28:0] w;
    checks++;
    if (rxq.size() == 0) begin
      errors++;
      $display("FAIL %s: no rx word captured, expected 0x%08h", name, exp);
    end else begin
      w = rxq.pop_front();
      void'(rxts.pop_front());
      if (w !== exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", name, w, exp);
      end
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget && rxq.size() < n; k++) @(posedge clk);
    #1;
  endtask

  // Presents one packet and holds it until the DUT consumes it.
  task automatic send(input logic [28:0] pkt);
    int k;
    @(posedge clk); #1;
    tx_data  = pkt;
    tx_empty = 1'b0;
    k = 0;
    @(negedge clk);
    while (!tx_rden && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!tx_rden) begin
      checks++;
      errors++;
      $display("FAIL send: tx_rden never rose for packet 0x%08h", pkt);
    end
    @(posedge clk); #1;
    tx_empty = 1'b1;
  endtask

  // Change-mode toggle: the pin-change cycle counts as cycle 1, the word is on rx in cycle 4.
  task automatic chg_toggle(input logic [15:0] v, input string nm);
    int c0;
    rxq.delete(); rxts.delete();
    @(posedge clk); #1;
    pins_in = v;
    c0 = cyc;
    repeat (8) @(posedge clk);
    #1;
    check({nm, "_count"}, rxq.size(), 1);
    if (rxts.size() > 0) check({nm, "_lat"}, rxts[0] - c0, 3);
    pop_check({nm, "_dat"}, smp(1'b0, 3'(exp_seq), {8'h00, v}));
    exp_seq = (exp_seq + 1) % 8;
  endtask

  initial begin
    int n_tot;
    vecs.push_back('{rd_pkt(3'd7),               1'b1, rsp(3'd7, 24'h000001),  16'h0000, 16'hFFFF});
    vecs.push_back('{rd_pkt(3'd1),               1'b1, rsp(3'd1, 24'd6250000), 16'h0000, 16'hFFFF});
    vecs.push_back('{wr_pkt(3'd2, 24'h0000FF),   1'b0, 29'd0,                  16'h0000, 16'hFF00});
    vecs.push_back('{29'h000A5A5,                1'b0, 29'd0,                  16'hA5A5, 16'hFF00});
    vecs.push_back('{rd_pkt(3'd2),               1'b1, rsp(3'd2, 24'h0000FF),  16'hA5A5, 16'hFF00});
    vecs.push_back('{wr_pkt(3'd3, 24'hABCDEF),   1'b0, 29'd0,                  16'hCDEF, 16'hFF00});
    vecs.push_back('{rd_pkt(3'd3),               1'b1, rsp(3'd3, 24'h00CDEF),  16'hCDEF, 16'hFF00});
    vecs.push_back('{wr_pkt(3'd7, 24'h123456),   1'b0, 29'd0,                  16'hCDEF, 16'hFF00});
    vecs.push_back('{rd_pkt(3'd7),               1'b1, rsp(3'd7, 24'h000001),  16'hCDEF, 16'hFF00});
    vecs.push_back('{rd_pkt(3'd6),               1'b1, rsp(3'd6, 24'h000000),  16'hCDEF, 16'hFF00});
    vecs.push_back('{rd_pkt(3'd4),               1'b1, rsp(3'd4, 24'h00FFFF),  16'hCDEF, 16'hFF00});
    vecs.push_back('{wr_pkt(3'd2, 24'hFFFFFF),   1'b0, 29'd0,                  16'hCDEF, 16'h0000});
    vecs.push_back('{rd_pkt(3'd2),               1'b1, rsp(3'd2, 24'h00FFFF),  16'hCDEF, 16'h0000});
    vecs.push_back('{rd_pkt(3'd0),               1'b1, rsp(3'd0, 24'h000000),  16'hCDEF, 16'h0000});
    vecs.push_back('{29'h0FFF1234,               1'b0, 29'd0,                  16'h1234, 16'h0000});
    vecs.push_back('{wr_pkt(3'd2, 24'h0000FF),   1'b0, 29'd0,                  16'h1234, 16'hFF00});

    rst_n    = 1'b1;
    tx_empty = 1'b1;
    tx_data  = '0;
    rx_full  = 1'b0;
    pins_in  = 16'h1234;
    #3 rst_n = 1'b0;
    #4;
    check("rst_out",   pins_out, 16'h0000);
    check("rst_tri",   pins_tri, 16'hFFFF);
    check("rst_wren",  rx_wren,  1'b0);
    check("rst_rden",  tx_rden,  1'b0);
    check("rst_idle",  idle,     1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Register path vectors.
    foreach (vecs[i]) begin
      rxq.delete(); rxts.delete();
      send(vecs[i].pkt);
      check($sformatf("vec%0d_out", i), pins_out, vecs[i].out_e);
      check($sformatf("vec%0d_tri", i), pins_tri, vecs[i].tri_e);
      if (vecs[i].has_resp) begin
        wait_rx(1, 20);
        pop_check($sformatf("vec%0d_resp", i), vecs[i].resp);
      end
    end

    // Periodic sampling, DIV=3: one word every 4 cycles, seq wraps after 7.
    rxq.delete(); rxts.delete();
    send(wr_pkt(3'd1, 24'd3));
    send(wr_pkt(3'd0, 24'h000001));
    wait_rx(10, 200);
    send(wr_pkt(3'd0, 24'h000000));
    repeat (10) @(posedge clk);
    #1;
    n_tot = rxq.size();
    for (int i = 1; i < 10; i++)
      if (i < rxts.size()) check($sformatf("per_gap%0d", i), rxts[i] - rxts[i-1], 4);
    for (int i = 0; i < 10; i++)
      pop_check($sformatf("per_smp%0d", i), smp(1'b0, 3'(i), 24'h001234));
    exp_seq = n_tot % 8;
    rxq.delete(); rxts.delete();

    // Change mode, only pin 0 watched, DIV=0.
    send(wr_pkt(3'd4, 24'h000001));
    send(wr_pkt(3'd1, 24'd0));
    send(wr_pkt(3'd0, 24'h000003));
    repeat (6) @(posedge clk);
    #1;
    check("chg_quiet", rxq.size(), 0);
    @(posedge clk); #1;
    pins_in = 16'h1236;
    repeat (8) @(posedge clk);
    #1;
    check("chg_masked_pin", rxq.size(), 0);
    chg_toggle(16'h1237, "chg_rise");
    chg_toggle(16'h1236, "chg_fall");
    send(wr_pkt(3'd0, 24'h000000));
    repeat (4) @(posedge clk);
    rxq.delete(); rxts.delete();

    // Overflow: rx held full while sampling every cycle, then drained.
    @(posedge clk); #1;
    rx_full = 1'b1;
    send(wr_pkt(3'd0, 24'h000001));
    repeat (20) @(posedge clk);
    send(wr_pkt(3'd0, 24'h000000));
    repeat (3) @(posedge clk);
    #1;
    check("ovf_none_while_full", rxq.size(), 0);
    rx_full = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ovf_drain_cnt", rxq.size(), 8);
    for (int i = 0; i < 8; i++)
      pop_check($sformatf("ovf_drain%0d", i), smp(1'b0, 3'((exp_seq + i) % 8), 24'h001236));
    rxq.delete(); rxts.delete();
    send(rd_pkt(3'd5));
    wait_rx(1, 20);
    pop_check("ovf_status_set", rsp(3'd5, 24'h000001));
    send(wr_pkt(3'd5, 24'h000000));
    send(rd_pkt(3'd5));
    wait_rx(1, 20);
    pop_check("ovf_status_clr", rsp(3'd5, 24'h000000));
    rxq.delete(); rxts.delete();
    send(wr_pkt(3'd1, 24'd3));
    send(wr_pkt(3'd0, 24'h000001));
    wait_rx(2, 50);
    send(wr_pkt(3'd0, 24'h000000));
    repeat (10) @(posedge clk);
    #1;
    pop_check("ovf_first_after", smp(1'b1, 3'(exp_seq), 24'h001236));
    pop_check("ovf_second_after", smp(1'b0, 3'((exp_seq + 1) % 8), 24'h001236));
    rxq.delete(); rxts.delete();

    // Config read while samples are queued and rx_full toggles.
    @(posedge clk); #1;
    rx_full = 1'b1;
    send(wr_pkt(3'd1, 24'd0));
    send(wr_pkt(3'd0, 24'h000001));
    repeat (12) @(posedge clk);
    send(wr_pkt(3'd0, 24'h000000));
    repeat (2) @(posedge clk);
    #1;
    tx_data  = rd_pkt(3'd5);
    tx_empty = 1'b0;
    @(negedge clk);
    check("arb_rd_accept", tx_rden, 1'b1);
    @(posedge clk); #1;
    tx_data = 29'h00000FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("arb_rden_hold%0d", i), tx_rden, 1'b0);
    end
    check("arb_idle_busy", idle, 1'b0);
    @(posedge clk); #1;
    rx_full = 1'b0;
    @(negedge clk);
    check("arb_resp_wren", rx_wren, 1'b1);
    check("arb_resp_dat", rx_data, rsp(3'd5, 24'h000801));
    check("arb_rden_until_written", tx_rden, 1'b0);
    @(posedge clk); #1;
    rx_full = 1'b1;
    @(negedge clk);
    check("arb_rden_after", tx_rden, 1'b1);
    @(posedge clk); #1;
    tx_empty = 1'b1;
    rx_full  = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("arb_total_words", rxq.size(), 9);
    pop_check("arb_first_word", rsp(3'd5, 24'h000801));
    if (rxq.size() > 0) check("arb_next_is_sample", {rxq[0][28], rxq[0][23:0]}, {1'b0, 24'h001236});
    check("arb_data_pkt_out", pins_out, 16'h00FF);
    check("arb_idle_end", idle, 1'b1);

    // Reset mid-operation discards queued samples and restores defaults.
    rxq.delete(); rxts.delete();
    @(posedge clk); #1;
    rx_full = 1'b1;
    send(wr_pkt(3'd0, 24'h000001));
    repeat (6) @(posedge clk);
    #1;
    check("mid_idle_busy", idle, 1'b0);
    rst_n   = 1'b0;
    rx_full = 1'b0;
    #1;
    check("mid_rst_out",  pins_out, 16'h0000);
    check("mid_rst_tri",  pins_tri, 16'hFFFF);
    check("mid_rst_idle", idle,     1'b1);
    check("mid_rst_wren", rx_wren,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_flushed", rxq.size(), 0);
    send(rd_pkt(3'd1));
    wait_rx(1, 20);
    pop_check("mid_rst_div", rsp(3'd1, 24'd6250000));

    check("no_wren_when_full", wren_full_hits, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
